multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32 core: replaces the free-running step toggle with an
//  FSM (fetch/decode/execute/mem/writeback) that gates PC update, IR load, register write
//  and memory access. Talks to instruction and data memory over req/ack handshakes and
//  traps on illegal opcodes or memory timeouts. Sits between control/alu_control and datapath.
// PARAMETERS
//  XLEN        32  datapath / counter width
//  MEM_TIMEOUT 16  max wait cycles for imem_ack/dmem_ack before trap (>=1)
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     asynchronous, active-high
//  run          in   1     1 = fetch next instruction; 0 = park in IDLE at next boundary
//  imem_req     out  1     instruction fetch request
//  imem_ack     in   1     fetch done; instr valid this cycle
//  instr        in   XLEN  fetched instruction word
//  dmem_req     out  1     data access request
//  dmem_we      out  1     1 = store, 0 = load (valid while dmem_req)
//  dmem_ack     in   1     data access done
//  alu_zero     in   1     ALU result == 0 (branch condition)
//  ir_en        out  1     load instruction register (1-cycle pulse)
//  pc_en        out  1     commit next PC (1-cycle pulse at retirement)
//  pc_sel       out  1     1 = jump address, 0 = pc+1; valid with pc_en
//  alu_src      out  1     1 = immediate operand
//  alu_op       out  4     2 = R-type, 0 = add (I/load/store), 7 = branch compare
//  mem_to_rgs   out  1     writeback selects read data
//  reg_wr       out  1     register file write enable (1-cycle pulse)
//  state        out  3     current FSM state
//  trap         out  1     sticky trap flag
//  trap_cause   out  2     0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
//  cycle_cnt    out  XLEN  active cycles (state not IDLE/TRAP), wraps mod 2^XLEN
//  instret      out  XLEN  retired instructions, wraps mod 2^XLEN
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; counters 0; trap cleared; reqs drop immediately.
//  States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6.
//  IDLE: run=1 -> FETCH next cycle, else stay.
//  FETCH: imem_req=1 until imem_ack sampled; on ack: ir_en=1 same cycle, latch instr[6:0]
//   internally, -> DECODE; req low next cycle. No ack in MEM_TIMEOUT cycles -> TRAP cause 2.
//  DECODE: opcode 0x33,0x13,0x03,0x23,0x63 -> EXEC; anything else -> TRAP cause 1.
//  EXEC: alu_src/alu_op/mem_to_rgs driven from latched opcode (held EXEC..WB).
//   0x33/0x13 -> WB; 0x03/0x23 -> MEM; 0x63: pc_en=1, pc_sel=alu_zero, instret+1,
//   -> FETCH if run=1 else IDLE.
//  MEM: dmem_req=1, dmem_we=(opcode==0x23) until dmem_ack. Load ack -> WB.
//   Store ack: pc_en=1, pc_sel=0, instret+1, -> FETCH/IDLE per run. Timeout -> TRAP cause 3.
//  WB: reg_wr=1, pc_en=1, pc_sel=0, instret+1, -> FETCH/IDLE per run. Single cycle.
//  TRAP: all strobes/reqs 0, trap=1; exit only by reset.
//  Latency: R/I = 4 cycles + fetch wait; load = 5 + waits; store = 4 + waits; branch = 3 + wait.
//  Handshake: ack ignored when req low; ack on same cycle as timeout expiry counts as ack.
//  run=0 mid-instruction: current instruction completes and retires, then IDLE.
//  Timeout counter clears on every entry to FETCH/MEM; counts cycles with req high.
//  ir_en, pc_en, reg_wr never asserted in same cycle except pc_en+reg_wr in WB.
// STRUCTURE
//  Shared package riscv_ctrl_pkg: opcode constants, state encodings, ALU_OP codes
//  (0/2/7), trap cause codes. Sub-module req_watchdog: clear/count/expired counter
//  sized $clog2(MEM_TIMEOUT+1), instanced once, shared by FETCH and MEM.
// TESTING
//  R-type 0x00208033, imem_ack 1 cycle after req -> reg_wr pulse in WB, instret=1, pc_sel=0.
//  Load 0x0000A083, dmem_ack after 3 waits -> dmem_we=0, mem_to_rgs=1, reg_wr once, instret=1.
//  Branch 0x00000063 with alu_zero=1 -> pc_en & pc_sel=1 in EXEC, no reg_wr, no dmem_req.
//  instr=0xFFFFFFFF -> TRAP, trap_cause=1, strobes 0, persists until reset; reset -> IDLE.
//  imem_ack held low MEM_TIMEOUT=16 cycles -> TRAP cause 2; ack on 16th cycle -> DECODE.
//  Assert reset mid-MEM store -> dmem_req drops same cycle, counters 0; run=0 after retire -> IDLE.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 sequencer: opcodes, state
// encodings, ALU operation codes, trap causes and the EXEC-phase decode.
package riscv_ctrl_pkg;

  localparam int unsigned OPC_W      = 7;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned STATE_W    = 3;
  localparam int unsigned CAUSE_W    = 2;

  // Opcodes the sequencer understands; anything else traps in DECODE.
  localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'h33;
  localparam logic [OPC_W-1:0] OPC_ITYPE  = 7'h13;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'h03;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'h23;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'h63;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD    = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_RTYPE  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_BRANCH = 4'd7;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } ctrl_state_e;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM_TO = 2'd2,
    CAUSE_DMEM_TO = 2'd3
  } trap_cause_e;

  // Datapath steering held from EXEC through WB.
  typedef struct packed {
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_to_rgs;
  } exec_ctrl_t;

  function automatic logic opcode_legal(input logic [OPC_W-1:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_ITYPE) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

  function automatic exec_ctrl_t exec_decode(input logic [OPC_W-1:0] opc);
    exec_ctrl_t c;
    c = '0;
    case (opc)
      OPC_RTYPE:  c.alu_op = ALU_OP_RTYPE;
      OPC_ITYPE:  begin c.alu_src = 1'b1; c.alu_op = ALU_OP_ADD; end
      OPC_LOAD:   begin c.alu_src = 1'b1; c.alu_op = ALU_OP_ADD; c.mem_to_rgs = 1'b1; end
      OPC_STORE:  begin c.alu_src = 1'b1; c.alu_op = ALU_OP_ADD; end
      OPC_BRANCH: c.alu_op = ALU_OP_BRANCH;
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/req_watchdog.sv
// Wait-cycle counter shared by the instruction-fetch and data-access phases.
//  clk, reset  : clock, async active-high reset
//  clear       : zero the count (takes priority over count_en)
//  count_en    : a request is outstanding this cycle
//  expired_c   : this is the last permitted wait cycle (combinational)
module req_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Count request cycles; saturate on the final cycle so it cannot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired_c = count_en && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32 core. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, gating IR load, PC update, register write and
// memory requests, and traps on illegal opcodes or memory timeouts.
//  clk, reset        : clock, async active-high reset
//  run               : keep fetching; 0 parks in IDLE after the current instruction
//  imem_req/ack      : instruction fetch handshake, instr valid with imem_ack
//  dmem_req/we/ack   : data access handshake, we=1 for store
//  alu_zero          : branch condition from the ALU
//  ir_en, pc_en      : IR load / PC commit strobes (same cycle as the handshake/retire)
//  pc_sel            : 1 = jump target, 0 = pc+1
//  alu_src, alu_op   : operand select and ALU function, held EXEC..WB
//  mem_to_rgs, reg_wr: writeback source and register write strobe
//  state             : current FSM state
//  trap, trap_cause  : sticky trap flag and reason
//  cycle_cnt, instret: active-cycle and retired-instruction counters
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] instr,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  input  logic            alu_zero,
  output logic            ir_en,
  output logic            pc_en,
  output logic            pc_sel,
  output logic            alu_src,
  output logic [3:0]      alu_op,
  output logic            mem_to_rgs,
  output logic            reg_wr,
  output logic [2:0]      state,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret
);

  ctrl_state_e      cur_state;
  ctrl_state_e      nxt_state;
  trap_cause_e      cause_q;
  trap_cause_e      nxt_cause;
  logic [OPC_W-1:0] opcode_q;
  exec_ctrl_t       nxt_exec;

  logic fetch_ack_c;
  logic mem_ack_c;
  logic waiting_c;
  logic retire_c;
  logic wd_expired_c;
  logic is_load_c;
  logic is_store_c;
  logic is_branch_c;
  logic unused_instr_bits;

  // Only the opcode field is needed here; the datapath consumes the rest.
  assign unused_instr_bits = ^instr[XLEN-1:OPC_W];

  assign is_load_c   = (opcode_q == OPC_LOAD);
  assign is_store_c  = (opcode_q == OPC_STORE);
  assign is_branch_c = (opcode_q == OPC_BRANCH);

  // Acks only count while the matching request is outstanding.
  assign fetch_ack_c = (cur_state == ST_FETCH) && imem_ack;
  assign mem_ack_c   = (cur_state == ST_MEM) && dmem_ack;
  assign waiting_c   = (cur_state == ST_FETCH) || (cur_state == ST_MEM);

  // Retirement: WB, a branch in EXEC, or a store completing in MEM.
  assign retire_c = (cur_state == ST_WB) ||
                    ((cur_state == ST_EXEC) && is_branch_c) ||
                    (mem_ack_c && is_store_c);

  // Handshake-coincident strobes must land in the ack/retire cycle itself.
  assign ir_en  = fetch_ack_c;
  assign pc_en  = retire_c;
  assign pc_sel = (cur_state == ST_EXEC) && is_branch_c && alu_zero;

  assign state      = cur_state;
  assign trap_cause = cause_q;

  // Cleared outside the wait states and on a completed handshake, so each
  // entry to FETCH or MEM starts from zero (store ack -> FETCH included).
  req_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (!waiting_c || fetch_ack_c || mem_ack_c),
    .count_en (waiting_c),
    .expired_c(wd_expired_c)
  );

  // Next-state and trap-cause selection.
  always_comb begin
    nxt_state = cur_state;
    nxt_cause = cause_q;
    nxt_exec  = '0;
    case (cur_state)
      ST_IDLE: begin
        if (run) nxt_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          nxt_state = ST_DECODE;
        end else if (wd_expired_c) begin
          nxt_state = ST_TRAP;
          nxt_cause = CAUSE_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (opcode_legal(opcode_q)) begin
          nxt_state = ST_EXEC;
        end else begin
          nxt_state = ST_TRAP;
          nxt_cause = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (is_load_c || is_store_c) nxt_state = ST_MEM;
        else if (is_branch_c)        nxt_state = run ? ST_FETCH : ST_IDLE;
        else                         nxt_state = ST_WB;
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (is_load_c) nxt_state = ST_WB;
          else           nxt_state = run ? ST_FETCH : ST_IDLE;
        end else if (wd_expired_c) begin
          nxt_state = ST_TRAP;
          nxt_cause = CAUSE_DMEM_TO;
        end
      end
      ST_WB: begin
        nxt_state = run ? ST_FETCH : ST_IDLE;
      end
      ST_TRAP: begin
        nxt_state = ST_TRAP;
      end
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase
    if ((nxt_state == ST_EXEC) || (nxt_state == ST_MEM) || (nxt_state == ST_WB))
      nxt_exec = exec_decode(opcode_q);
  end

  // State, opcode latch, registered outputs and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state  <= ST_IDLE;
      cause_q    <= CAUSE_NONE;
      opcode_q   <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      alu_src    <= 1'b0;
      alu_op     <= '0;
      mem_to_rgs <= 1'b0;
      reg_wr     <= 1'b0;
      trap       <= 1'b0;
      cycle_cnt  <= '0;
      instret    <= '0;
    end else begin
      cur_state  <= nxt_state;
      cause_q    <= nxt_cause;
      if (fetch_ack_c) opcode_q <= instr[OPC_W-1:0];
      imem_req   <= (nxt_state == ST_FETCH);
      dmem_req   <= (nxt_state == ST_MEM);
      dmem_we    <= (nxt_state == ST_MEM) && is_store_c;
      alu_src    <= nxt_exec.alu_src;
      alu_op     <= nxt_exec.alu_op;
      mem_to_rgs <= nxt_exec.mem_to_rgs;
      reg_wr     <= (nxt_state == ST_WB);
      trap       <= (nxt_state == ST_TRAP);
      if ((cur_state != ST_IDLE) && (cur_state != ST_TRAP))
        cycle_cnt <= cycle_cnt + XLEN'(1);
      if (retire_c)
        instret <= instret + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: inputs change just after the falling
// edge and outputs are sampled 1ns later, mid-way between rising edges.
module tb_multicycle_ctrl;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned MEM_TIMEOUT = 16;

  logic            clk;
  logic            reset;
  logic            run;
  logic            imem_req;
  logic            imem_ack;
  logic [XLEN-1:0] instr;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;
  logic            alu_zero;
  logic            ir_en;
  logic            pc_en;
  logic            pc_sel;
  logic            alu_src;
  logic [3:0]      alu_op;
  logic            mem_to_rgs;
  logic            reg_wr;
  logic [2:0]      state;
  logic            trap;
  logic [1:0]      trap_cause;
  logic [XLEN-1:0] cycle_cnt;
  logic [XLEN-1:0] instret;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(
    .XLEN(XLEN),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_zero(alu_zero), .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel),
    .alu_src(alu_src), .alu_op(alu_op), .mem_to_rgs(mem_to_rgs),
    .reg_wr(reg_wr), .state(state), .trap(trap), .trap_cause(trap_cause),
    .cycle_cnt(cycle_cnt), .instret(instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1);
  end

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0; instr = '0;
    #1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
    total++; if ({ir_en, pc_en, reg_wr, imem_req, dmem_req, dmem_we} !== 6'b0) begin bad++;
      $display("FAIL rst_strobes got=%b want=000000", {ir_en, pc_en, reg_wr, imem_req, dmem_req, dmem_we}); end
    total++; if ({trap, trap_cause} !== 3'b0) begin bad++; $display("FAIL rst_trap got=%b want=000", {trap, trap_cause}); end
    total++; if ({cycle_cnt, instret} !== 64'd0) begin bad++;
      $display("FAIL rst_counters got=%0d/%0d want=0/0", cycle_cnt, instret); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    total++; if ({state, imem_req} !== {3'd0, 1'b0}) begin bad++;
      $display("FAIL rst_idle_hold got=%b want=0000", {state, imem_req}); end
  endtask

  task automatic test_rtype();
    @(negedge clk); run = 1'b1;
    @(negedge clk); #1;
    total++; if ({state, imem_req, ir_en} !== {3'd1, 1'b1, 1'b0}) begin bad++;
      $display("FAIL rt_fetch got=%b want=00110", {state, imem_req, ir_en}); end
    @(negedge clk); imem_ack = 1'b1; instr = 32'h00208033; run = 1'b0; #1;
    total++; if ({state, ir_en, pc_en, reg_wr} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin bad++;
      $display("FAIL rt_ir_en got=%b want=001100", {state, ir_en, pc_en, reg_wr}); end
    @(negedge clk); imem_ack = 1'b0; instr = '0; #1;
    total++; if ({state, imem_req, ir_en} !== {3'd2, 1'b0, 1'b0}) begin bad++;
      $display("FAIL rt_decode got=%b want=01000", {state, imem_req, ir_en}); end
    @(negedge clk); #1;
    total++; if ({state, alu_src, alu_op, pc_en} !== {3'd3, 1'b0, 4'd2, 1'b0}) begin bad++;
      $display("FAIL rt_exec got=%b want=011000100", {state, alu_src, alu_op, pc_en}); end
    @(negedge clk); #1;
    total++; if ({state, reg_wr, pc_en, pc_sel, mem_to_rgs, alu_op} !== {3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2}) begin bad++;
      $display("FAIL rt_wb got=%b want=101110000010", {state, reg_wr, pc_en, pc_sel, mem_to_rgs, alu_op}); end
    @(negedge clk); #1;
    total++; if ({state, reg_wr, pc_en} !== {3'd0, 1'b0, 1'b0}) begin bad++;
      $display("FAIL rt_park got=%b want=00000", {state, reg_wr, pc_en}); end
    total++; if ({instret, cycle_cnt} !== {32'd1, 32'd5}) begin bad++;
      $display("FAIL rt_counters instret=%0d cycles=%0d want 1/5", instret, cycle_cnt); end
  endtask

  task automatic test_load();
    @(negedge clk); run = 1'b1;
    @(negedge clk); imem_ack = 1'b1; instr = 32'h0000A083; run = 1'b0; #1;
    total++; if ({state, ir_en} !== {3'd1, 1'b1}) begin bad++; $display("FAIL ld_fetch got=%b want=0011", {state, ir_en}); end
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk); #1;
    total++; if ({state, alu_src, alu_op, mem_to_rgs} !== {3'd3, 1'b1, 4'd0, 1'b1}) begin bad++;
      $display("FAIL ld_exec got=%b want=011100001", {state, alu_src, alu_op, mem_to_rgs}); end
    for (int w = 0; w < 3; w++) begin
      @(negedge clk); #1;
      total++; if ({state, dmem_req, dmem_we, pc_en, reg_wr} !== {3'd4, 1'b1, 1'b0, 1'b0, 1'b0}) begin bad++;
        $display("FAIL ld_mem_wait%0d got=%b want=1001000", w, {state, dmem_req, dmem_we, pc_en, reg_wr}); end
    end
    @(negedge clk); dmem_ack = 1'b1; #1;
    total++; if ({state, pc_en, reg_wr, dmem_we} !== {3'd4, 1'b0, 1'b0, 1'b0}) begin bad++;
      $display("FAIL ld_ack got=%b want=100000", {state, pc_en, reg_wr, dmem_we}); end
    @(negedge clk); dmem_ack = 1'b0; #1;
    total++; if ({state, reg_wr, pc_en, mem_to_rgs, dmem_req} !== {3'd5, 1'b1, 1'b1, 1'b1, 1'b0}) begin bad++;
      $display("FAIL ld_wb got=%b want=1011110", {state, reg_wr, pc_en, mem_to_rgs, dmem_req}); end
    @(negedge clk); #1;
    total++; if ({state, reg_wr, instret, cycle_cnt} !== {3'd0, 1'b0, 32'd2, 32'd13}) begin bad++;
      $display("FAIL ld_done state=%0d reg_wr=%b instret=%0d cycles=%0d want 0/0/2/13", state, reg_wr, instret, cycle_cnt); end
  endtask

  task automatic test_branch();
    @(negedge clk); run = 1'b1;
    @(negedge clk); imem_ack = 1'b1; instr = 32'h00000063; run = 1'b0; alu_zero = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk); #1;
    total++; if ({state, pc_en, pc_sel, alu_op, alu_src, reg_wr, dmem_req} !== {3'd3, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0}) begin bad++;
      $display("FAIL br_taken got=%b want=011110111000", {state, pc_en, pc_sel, alu_op, alu_src, reg_wr, dmem_req}); end
    @(negedge clk); alu_zero = 1'b0; #1;
    total++; if ({state, pc_en, dmem_req, reg_wr, instret, cycle_cnt} !== {3'd0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd16}) begin bad++;
      $display("FAIL br_done state=%0d instret=%0d cycles=%0d want 0/3/16", state, instret, cycle_cnt); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); run = 1'b1;
    @(negedge clk); imem_ack = 1'b1; instr = 32'h00000063; alu_zero = 1'b0;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk); #1;
    total++; if ({state, pc_en, pc_sel} !== {3'd3, 1'b1, 1'b0}) begin bad++;
      $display("FAIL b2b_br_nt got=%b want=01110", {state, pc_en, pc_sel}); end
    @(negedge clk); imem_ack = 1'b1; instr = 32'h00500093; run = 1'b0; #1;
    total++; if ({state, imem_req, ir_en, instret} !== {3'd1, 1'b1, 1'b1, 32'd4}) begin bad++;
      $display("FAIL b2b_refetch state=%0d req=%b ir_en=%b instret=%0d want 1/1/1/4", state, imem_req, ir_en, instret); end
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk); #1;
    total++; if ({state, alu_src, alu_op, mem_to_rgs} !== {3'd3, 1'b1, 4'd0, 1'b0}) begin bad++;
      $display("FAIL b2b_itype_exec got=%b want=011100000", {state, alu_src, alu_op, mem_to_rgs}); end
    @(negedge clk); #1;
    total++; if ({state, reg_wr, pc_en, ir_en} !== {3'd5, 1'b1, 1'b1, 1'b0}) begin bad++;
      $display("FAIL b2b_itype_wb got=%b want=101110", {state, reg_wr, pc_en, ir_en}); end
    @(negedge clk); #1;
    total++; if ({state, instret, cycle_cnt} !== {3'd0, 32'd5, 32'd23}) begin bad++;
      $display("FAIL b2b_done state=%0d instret=%0d cycles=%0d want 0/5/23", state, instret, cycle_cnt); end
  endtask

  task automatic test_store();
    @(negedge clk); run = 1'b1;
    @(negedge clk); imem_ack = 1'b1; instr = 32'h0020A023; run = 1'b0;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk); #1;
    total++; if ({state, alu_src, alu_op} !== {3'd3, 1'b1, 4'd0}) begin bad++;
      $display("FAIL st_exec got=%b want=01110000", {state, alu_src, alu_op}); end
    @(negedge clk); #1;
    total++; if ({state, dmem_req, dmem_we, pc_en} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin bad++;
      $display("FAIL st_mem got=%b want=100110", {state, dmem_req, dmem_we, pc_en}); end
    @(negedge clk); dmem_ack = 1'b1; #1;
    total++; if ({state, pc_en, pc_sel, reg_wr} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin bad++;
      $display("FAIL st_retire got=%b want=100100", {state, pc_en, pc_sel, reg_wr}); end
    @(negedge clk); dmem_ack = 1'b0; #1;
    total++; if ({state, dmem_req, dmem_we, instret, cycle_cnt} !== {3'd0, 1'b0, 1'b0, 32'd6, 32'd28}) begin bad++;
      $display("FAIL st_done state=%0d req=%b instret=%0d cycles=%0d want 0/0/6/28", state, dmem_req, instret, cycle_cnt); end
  endtask

  task automatic test_reset_mid_store();
    @(negedge clk); run = 1'b1;
    @(negedge clk); imem_ack = 1'b1; instr = 32'h0020A023;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    total++; if ({state, dmem_req, dmem_we} !== {3'd4, 1'b1, 1'b1}) begin bad++;
      $display("FAIL rms_in_mem got=%b want=10011", {state, dmem_req, dmem_we}); end
    #1 reset = 1'b1; #1;
    total++; if ({state, dmem_req, dmem_we, pc_en} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin bad++;
      $display("FAIL rms_async_drop got=%b want=000000", {state, dmem_req, dmem_we, pc_en}); end
    total++; if ({instret, cycle_cnt} !== 64'd0) begin bad++;
      $display("FAIL rms_counters instret=%0d cycles=%0d want 0/0", instret, cycle_cnt); end
    run = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    total++; if ({state, imem_req} !== {3'd0, 1'b0}) begin bad++;
      $display("FAIL rms_idle got=%b want=0000", {state, imem_req}); end
  endtask

  task automatic test_ack_on_last_then_illegal();
    @(negedge clk); run = 1'b1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk); #1;
      total++; if ({state, imem_req} !== {3'd1, 1'b1}) begin bad++;
        $display("FAIL il_fetch_wait%0d got=%b want=0011", i, {state, imem_req}); end
    end
    @(negedge clk); imem_ack = 1'b1; instr = 32'hFFFFFFFF; run = 1'b0; #1;
    total++; if ({state, ir_en} !== {3'd1, 1'b1}) begin bad++;
      $display("FAIL il_ack_last got=%b want=0011", {state, ir_en}); end
    @(negedge clk); imem_ack = 1'b0; #1;
    total++; if ({state, trap} !== {3'd2, 1'b0}) begin bad++;
      $display("FAIL il_decode got=%b want=0100", {state, trap}); end
    @(negedge clk); #1;
    total++; if ({state, trap, trap_cause} !== {3'd6, 1'b1, 2'd1}) begin bad++;
      $display("FAIL il_trap got=%b want=110101", {state, trap, trap_cause}); end
    run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; alu_zero = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    total++; if ({state, trap, trap_cause, ir_en, pc_en, pc_sel, reg_wr, imem_req, dmem_req} !==
                 {3'd6, 1'b1, 2'd1, 6'b0}) begin bad++;
      $display("FAIL il_sticky got=%b want=110101000000",
               {state, trap, trap_cause, ir_en, pc_en, pc_sel, reg_wr, imem_req, dmem_req}); end
    reset = 1'b1; #1;
    total++; if ({state, trap, trap_cause} !== 6'b0) begin bad++;
      $display("FAIL il_reset_clears got=%b want=000000", {state, trap, trap_cause}); end
    run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_imem_timeout();
    @(negedge clk); run = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); #1;
      total++; if (state !== 3'd1) begin bad++; $display("FAIL it_wait%0d got=%0d want=1", i, state); end
    end
    @(negedge clk); #1;
    total++; if ({state, trap, trap_cause, imem_req} !== {3'd6, 1'b1, 2'd2, 1'b0}) begin bad++;
      $display("FAIL it_trap got=%b want=1101100", {state, trap, trap_cause, imem_req}); end
    pulse_reset();
  endtask

  task automatic test_dmem_timeout();
    @(negedge clk); run = 1'b1;
    @(negedge clk); imem_ack = 1'b1; instr = 32'h0000A083; run = 1'b0;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); #1;
      total++; if ({state, dmem_req} !== {3'd4, 1'b1}) begin bad++;
        $display("FAIL dt_wait%0d got=%b want=1001", i, {state, dmem_req}); end
    end
    @(negedge clk); #1;
    total++; if ({state, trap, trap_cause, dmem_req, reg_wr} !== {3'd6, 1'b1, 2'd3, 1'b0, 1'b0}) begin bad++;
      $display("FAIL dt_trap got=%b want=11011100", {state, trap, trap_cause, dmem_req, reg_wr}); end
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_branch();
    test_back_to_back();
    test_store();
    test_reset_mid_store();
    test_ack_on_last_then_illegal();
    test_imem_timeout();
    test_dmem_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
